// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: byte-wide memory read port, instruction
// hand-off to the control unit, PC load and the fetch error flag.
// The master modport is the fetch stage; the slave modport is the environment
// (memory + control unit).
interface instr_fetch_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic [7:0]        OPCODE;
   logic [7:0]        operand;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              fetch_err;

   modport master (
      output mem_addr, mem_rd, OPCODE, operand, instr_pc, instr_valid, fetch_err,
      input  mem_ack, mem_rdata, instr_ready, pc_load, pc_load_addr
   );

   modport slave (
      input  mem_addr, mem_rd, OPCODE, operand, instr_pc, instr_valid, fetch_err,
      output mem_ack, mem_rdata, instr_ready, pc_load, pc_load_addr
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads opcode (and optional immediate
// when opcode bit 7 is set) from a byte memory over req/ack, and hands the
// assembled instruction to the control unit over valid/ready. A PC load
// flushes any fetch in flight.
// Optional build macro FETCH_TIMEOUT_EN adds a wait-cycle watchdog that
// parks the stage in ERR with a sticky fetch_err until reset.
module instr_fetch #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
   parameter int                TIMEOUT  = 15
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);

   typedef enum logic [2:0] {
      REQ_OP   = 3'd0,
      WAIT_OP  = 3'd1,
      REQ_IMM  = 3'd2,
      WAIT_IMM = 3'd3,
      VALID    = 3'd4
`ifdef FETCH_TIMEOUT_EN
      , ERR    = 3'd5
`endif
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_rd_r;
   logic [7:0]        opcode_r;
   logic [7:0]        operand_r;
   logic [ADDR_W-1:0] instr_pc_r;
   logic              instr_valid_r;

`ifdef FETCH_TIMEOUT_EN
   localparam int             CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] wait_cnt_r;
   logic             fetch_err_r;

   // True when one more ack-less cycle makes the wait count reach TIMEOUT.
   function automatic logic last_wait(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_W'(TIMEOUT - 1));
   endfunction
`endif

   // Fetch FSM: PC, memory request, instruction registers and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= REQ_OP;
         pc_r          <= RESET_PC;
         mem_addr_r    <= RESET_PC;
         mem_rd_r      <= 1'b0;
         opcode_r      <= 8'h00;
         operand_r     <= 8'h00;
         instr_pc_r    <= RESET_PC;
         instr_valid_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt_r    <= {CNT_W{1'b0}};
         fetch_err_r   <= 1'b0;
      end else if (state_r == ERR) begin
         // ERR is terminal until reset; keep the bus quiet.
         state_r       <= ERR;
         mem_rd_r      <= 1'b0;
         instr_valid_r <= 1'b0;
`endif
      end else if (bus.pc_load) begin
         // Dropping mem_rd cancels any outstanding request; a same-cycle ack is discarded.
         pc_r          <= bus.pc_load_addr;
         mem_rd_r      <= 1'b0;
         instr_valid_r <= 1'b0;
         state_r       <= REQ_OP;
      end else begin
         case (state_r)
            REQ_OP: begin
               mem_rd_r   <= 1'b1;
               mem_addr_r <= pc_r;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt_r <= {CNT_W{1'b0}};
`endif
               state_r    <= WAIT_OP;
            end
            WAIT_OP: begin
               if (bus.mem_ack) begin
                  opcode_r   <= bus.mem_rdata;
                  instr_pc_r <= pc_r;
                  pc_r       <= pc_r + PC_ONE;
                  mem_rd_r   <= 1'b0;
                  if (bus.mem_rdata[7]) begin
                     state_r <= REQ_IMM;
                  end else begin
                     operand_r     <= 8'h00;
                     instr_valid_r <= 1'b1;
                     state_r       <= VALID;
                  end
`ifdef FETCH_TIMEOUT_EN
               end else if (last_wait(wait_cnt_r)) begin
                  fetch_err_r   <= 1'b1;
                  mem_rd_r      <= 1'b0;
                  instr_valid_r <= 1'b0;
                  state_r       <= ERR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_ONE;
`endif
               end
            end
            REQ_IMM: begin
               mem_rd_r   <= 1'b1;
               mem_addr_r <= pc_r;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt_r <= {CNT_W{1'b0}};
`endif
               state_r    <= WAIT_IMM;
            end
            WAIT_IMM: begin
               if (bus.mem_ack) begin
                  operand_r     <= bus.mem_rdata;
                  pc_r          <= pc_r + PC_ONE;
                  mem_rd_r      <= 1'b0;
                  instr_valid_r <= 1'b1;
                  state_r       <= VALID;
`ifdef FETCH_TIMEOUT_EN
               end else if (last_wait(wait_cnt_r)) begin
                  fetch_err_r   <= 1'b1;
                  mem_rd_r      <= 1'b0;
                  instr_valid_r <= 1'b0;
                  state_r       <= ERR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_ONE;
`endif
               end
            end
            VALID: begin
               // Outputs hold until the control unit takes the instruction.
               if (bus.instr_ready) begin
                  instr_valid_r <= 1'b0;
                  state_r       <= REQ_OP;
               end
            end
            default: begin
               mem_rd_r      <= 1'b0;
               instr_valid_r <= 1'b0;
               state_r       <= REQ_OP;
            end
         endcase
      end
   end

   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_rd      = mem_rd_r;
   assign bus.OPCODE      = opcode_r;
   assign bus.operand     = operand_r;
   assign bus.instr_pc    = instr_pc_r;
   assign bus.instr_valid = instr_valid_r;
`ifdef FETCH_TIMEOUT_EN
   assign bus.fetch_err   = fetch_err_r;
`else
   assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural byte memory with programmable
// wait states, expected instructions queued as stimulus is set up and popped
// when the DUT presents them.
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(8)) bus ();

   instr_fetch #(
      .ADDR_W  (8),
      .RESET_PC(8'h10),
      .TIMEOUT (15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- memory model ----------------
   logic [7:0] mem [0:255];
   logic [3:0] wcnt;
   int         wait_cycles;
   logic       no_ack;

   always @(posedge clk) begin
      if (!bus.mem_rd || bus.mem_ack) wcnt <= 4'd0;
      else                            wcnt <= wcnt + 4'd1;
   end

   assign bus.mem_ack   = bus.mem_rd && !no_ack && (int'(wcnt) >= wait_cycles);
   assign bus.mem_rdata = mem[bus.mem_addr];

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] op;
      logic [7:0] imm;
      logic [7:0] pc;
   } instr_t;

   instr_t sb[$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] op, input logic [7:0] imm, input logic [7:0] pc);
      instr_t e;
      e.op = op; e.imm = imm; e.pc = pc;
      sb.push_back(e);
   endtask

   // Wait (bounded) for instr_valid, then compare against the oldest expectation.
   task automatic get_instr(input string tag);
      int n = 0;
      instr_t e;
      while (!bus.instr_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
      check({tag, "_sb_has"}, {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_opcode"},  {24'd0, bus.OPCODE},   {24'd0, e.op});
         check({tag, "_operand"}, {24'd0, bus.operand},  {24'd0, e.imm});
         check({tag, "_pc"},      {24'd0, bus.instr_pc}, {24'd0, e.pc});
      end
   endtask

   task automatic accept(input string tag);
      bus.instr_ready = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, bus.instr_valid}, 32'd0);
   endtask

   task automatic check_req(input string tag, input logic [7:0] addr);
      check({tag, "_rd"},   {31'd0, bus.mem_rd},  32'd1);
      check({tag, "_addr"}, {24'd0, bus.mem_addr}, {24'd0, addr});
   endtask

   task automatic do_pc_load(input logic [7:0] addr, input logic ready);
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = addr;
      bus.instr_ready  = ready;
      @(negedge clk);
      bus.pc_load      = 1'b0;
      bus.instr_ready  = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h05;
      mem[8'h20] = 8'h83;
      mem[8'h21] = 8'h7A;
      mem[8'h22] = 8'h01;
      mem[8'h23] = 8'h55;
      mem[8'h40] = 8'h07;
      mem[8'hFF] = 8'h90;
      mem[8'h00] = 8'h3C;
      mem[8'h50] = 8'h0A;

      rst              = 1'b1;
      wait_cycles      = 0;
      no_ack           = 1'b0;
      bus.instr_ready  = 1'b0;
      bus.pc_load      = 1'b0;
      bus.pc_load_addr = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mem_rd",   {31'd0, bus.mem_rd},      32'd0);
      check("rst_mem_addr", {24'd0, bus.mem_addr},    32'h10);
      check("rst_opcode",   {24'd0, bus.OPCODE},      32'h00);
      check("rst_operand",  {24'd0, bus.operand},     32'h00);
      check("rst_instr_pc", {24'd0, bus.instr_pc},    32'h10);
      check("rst_valid",    {31'd0, bus.instr_valid}, 32'd0);
      check("rst_err",      {31'd0, bus.fetch_err},   32'd0);

      // First fetch from RESET_PC, opcode-only, zero-wait
      rst = 1'b0;
      push_exp(8'h05, 8'h00, 8'h10);
      @(negedge clk);
      check_req("req10", 8'h10);
      get_instr("i10");
      accept("acc10");
      @(negedge clk);
      check_req("req11", 8'h11);
      push_exp(8'h00, 8'h00, 8'h11);
      get_instr("i11");

      // PC load while VALID, opcode + immediate
      push_exp(8'h83, 8'h7A, 8'h20);
      do_pc_load(8'h20, 1'b0);
      check("ld20_rd_low", {31'd0, bus.mem_rd},      32'd0);
      check("ld20_vflush", {31'd0, bus.instr_valid}, 32'd0);
      @(negedge clk);
      check_req("req20", 8'h20);
      @(negedge clk);
      check("imm_gap_rd", {31'd0, bus.mem_rd}, 32'd0);
      @(negedge clk);
      check_req("req21", 8'h21);
      get_instr("i20");

      // Stall: outputs stable, no memory traffic
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_valid",   {31'd0, bus.instr_valid}, 32'd1);
         check("stall_rd",      {31'd0, bus.mem_rd},      32'd0);
         check("stall_opcode",  {24'd0, bus.OPCODE},      32'h83);
         check("stall_operand", {24'd0, bus.operand},     32'h7A);
         check("stall_pc",      {24'd0, bus.instr_pc},    32'h20);
      end
      accept("acc20");
      @(negedge clk);
      check_req("req22", 8'h22);
      push_exp(8'h01, 8'h00, 8'h22);
      get_instr("i22");

      // Wait-state memory; PC load lands in the same cycle as the ack
      wait_cycles = 3;
      accept("acc22");
      n = 0;
      while (!bus.mem_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ws_ack_seen", {31'd0, bus.mem_ack},  32'd1);
      check("ws_addr23",   {24'd0, bus.mem_addr}, 32'h23);
      push_exp(8'h07, 8'h00, 8'h40);
      do_pc_load(8'h40, 1'b0);
      check("ws_rd_low",    {31'd0, bus.mem_rd},      32'd0);
      check("ws_discard",   {24'd0, bus.OPCODE},      32'h01);
      check("ws_valid_low", {31'd0, bus.instr_valid}, 32'd0);
      @(negedge clk);
      check_req("req40", 8'h40);
      get_instr("i40");
      wait_cycles = 0;

      // PC wrap: opcode at 0xFF, immediate at 0x00; pc_load beats instr_ready
      push_exp(8'h90, 8'h3C, 8'hFF);
      do_pc_load(8'hFF, 1'b1);
      check("wrap_valid_low", {31'd0, bus.instr_valid}, 32'd0);
      check("wrap_rd_low",    {31'd0, bus.mem_rd},      32'd0);
      @(negedge clk);
      check_req("reqFF", 8'hFF);
      @(negedge clk);
      @(negedge clk);
      check_req("req00", 8'h00);
      get_instr("iFF");
      accept("accFF");
      @(negedge clk);
      check_req("req01", 8'h01);
      push_exp(8'h00, 8'h00, 8'h01);
      get_instr("i01");

`ifdef FETCH_TIMEOUT_EN
      // Memory never acks: error after 15 wait cycles, sticky until reset
      no_ack = 1'b1;
      do_pc_load(8'h50, 1'b0);
      @(negedge clk);
      check_req("req50", 8'h50);
      repeat (14) @(negedge clk);
      check("to_not_yet_err", {31'd0, bus.fetch_err}, 32'd0);
      check("to_not_yet_rd",  {31'd0, bus.mem_rd},    32'd1);
      @(negedge clk);
      check("to_err",   {31'd0, bus.fetch_err},   32'd1);
      check("to_rd",    {31'd0, bus.mem_rd},      32'd0);
      check("to_valid", {31'd0, bus.instr_valid}, 32'd0);
      no_ack = 1'b0;
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 8'h20;
      repeat (3) @(negedge clk);
      bus.pc_load = 1'b0;
      @(negedge clk);
      check("err_sticky", {31'd0, bus.fetch_err}, 32'd1);
      check("err_rd",     {31'd0, bus.mem_rd},    32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("err_cleared", {31'd0, bus.fetch_err}, 32'd0);
      check("err_rst_pc",  {24'd0, bus.mem_addr},  32'h10);
      push_exp(8'h05, 8'h00, 8'h10);
      @(negedge clk);
      check_req("req10b", 8'h10);
      get_instr("i10b");
`else
      // Memory stalls for a long time: request held, no error
      no_ack = 1'b1;
      do_pc_load(8'h50, 1'b0);
      @(negedge clk);
      check_req("req50", 8'h50);
      repeat (20) @(negedge clk);
      check_req("hold50", 8'h50);
      check("hold_err",   {31'd0, bus.fetch_err},   32'd0);
      check("hold_valid", {31'd0, bus.instr_valid}, 32'd0);
      push_exp(8'h0A, 8'h00, 8'h50);
      no_ack = 1'b0;
      get_instr("i50");
`endif

      check("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
